// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset controller.
package reset_sequencer_pkg;

    // Sequencer phases; one stage at a time walks HOLD -> RELEASE -> WAIT.
    typedef enum logic [2:0] {
        ASSERT  = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } seq_state_e;

    // Cycles to wait for a stage's ready before flagging it and moving on.
    localparam int DEFAULT_WAIT_LIMIT = 255;

    // Width of the stage index; never below one bit so a single-stage
    // build still has a legal index register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Shared down-counter used to time both the hold and the ready-wait of the
// active stage. Loads take priority over counting; the count stops at zero.
module stage_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load, else saturating decrement while enabled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all downstream domains in reset, then
// releases them one by one (stage 0 first), each after its hold time and
// an optional ready handshake. A soft-reset pulse restarts the sequence.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STAGES        = 3,
    parameter int COUNTER_WIDTH = 8,
    parameter int WAIT_LIMIT    = DEFAULT_WAIT_LIMIT
) (
    input  logic                            clk_in,
    input  logic                            reset,
    input  logic                            soft_reset_req,
    input  logic [STAGES*COUNTER_WIDTH-1:0] stage_hold,
    input  logic [STAGES-1:0]               stage_ready,
    output logic [STAGES-1:0]               stage_reset,
    output logic                            busy,
    output logic                            done,
    output logic [STAGES-1:0]               err_stage
);

    localparam int                       KW        = clog2(STAGES);
    localparam logic [KW-1:0]            LAST_K    = KW'(STAGES - 1);
    localparam logic [COUNTER_WIDTH-1:0] WAIT_LOAD = COUNTER_WIDTH'(WAIT_LIMIT);

    seq_state_e               state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [STAGES-1:0]        stage_reset_q, stage_reset_d;
    logic [STAGES-1:0]        err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     timer_load;
    logic                     timer_enable;
    logic                     timer_zero;
    logic [COUNTER_WIDTH-1:0] timer_value;

    // Hold time of stage idx; a programmed 0 counts as 1 cycle.
    function automatic logic [COUNTER_WIDTH-1:0] hold_for(
        input logic [STAGES*COUNTER_WIDTH-1:0] holds,
        input logic [KW-1:0]                   idx
    );
        logic [COUNTER_WIDTH-1:0] v;
        v = holds[int'(idx)*COUNTER_WIDTH +: COUNTER_WIDTH];
        return (v == '0) ? COUNTER_WIDTH'(1) : v;
    endfunction

    stage_timer #(
        .WIDTH (COUNTER_WIDTH)
    ) u_timer (
        .clk_i        (clk_in),
        .rst_ni       (reset),
        .load_i       (timer_load),
        .load_value_i (timer_value),
        .enable_i     (timer_enable),
        .zero_o       (timer_zero)
    );

    // Next-state, stage index, timer control and registered-output updates.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        stage_reset_d = stage_reset_q;
        err_d         = err_q;
        busy_d        = (state_q != DONE);
        done_d        = (state_q == DONE);
        timer_load    = 1'b0;
        timer_enable  = 1'b0;
        timer_value   = WAIT_LOAD;

        if (soft_reset_req) begin
            // Restart beats every other transition, including a WAIT exit.
            state_d       = ASSERT;
            k_d           = '0;
            stage_reset_d = '1;
            err_d         = '0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    stage_reset_d = '1;
                    k_d           = '0;
                    state_d       = HOLD;
                    timer_load    = 1'b1;
                    timer_value   = hold_for(stage_hold, '0);
                end
                HOLD: begin
                    timer_enable = 1'b1;
                    if (timer_zero) begin
                        state_d            = RELEASE;
                        stage_reset_d[k_q] = 1'b0;
                    end
                end
                RELEASE: begin
                    state_d     = WAIT;
                    timer_load  = 1'b1;
                    timer_value = WAIT_LOAD;
                end
                WAIT: begin
                    timer_enable = 1'b1;
                    if (stage_ready[k_q] || timer_zero) begin
                        // Ready seen on the last count still counts as ready.
                        if (!stage_ready[k_q]) begin
                            err_d[k_q] = 1'b1;
                        end
                        if (k_q == LAST_K) begin
                            state_d = DONE;
                        end else begin
                            k_d         = k_q + KW'(1);
                            state_d     = HOLD;
                            timer_load  = 1'b1;
                            timer_value = hold_for(stage_hold, k_q + KW'(1));
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    // Sequencer registers; reset puts every domain back into reset.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= ASSERT;
            k_q           <= '0;
            stage_reset_q <= '1;
            err_q         <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stage_reset_q <= stage_reset_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign stage_reset = stage_reset_q;
    assign err_stage   = err_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
